fp_issue_ctrl: RTL
==================

# fp_issue_ctrl

Single-outstanding issue and completion controller for the floating-point path, directly downstream of the decode-stage controller. Consumes `IsFpD`, `FpOpD` and the decode-stage instruction word, and accepts one FP operation at the D→E boundary. Times that operation with a per-operation latency counter and produces the FP register-file writeback strobe. Stalls decode on structural and RAW hazards against the pending FP destination.

## Interface
Parameters:
- `LAT_ADD`, default 3: cycles from start to writeback for FADD.S and FSUB.S. Legal range 1..31.
- `LAT_MUL`, default 4: cycles for FMUL.S. Legal range 1..31.
- `LAT_DIV`, default 12: cycles for FDIV.S. Legal range 1..31.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `InstrD`  in  32  decode-stage instruction. rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- `IsFpD`  in  1  decode-stage instruction is an FP op.
- `FpOpD`  in  2  00 add, 01 sub, 10 mul, 11 div.
- `AdvanceD`  in  1  D→E register loads this edge (not stalled by other hazards).
- `FlushE`  in  1  D→E register cleared this edge.
- `FpStallD`  out  1  hold F/D; OR into the stall logic.
- `FpStartE`  out  1  one-cycle start pulse to the FP datapath.
- `FpOpE`  out  2  latched operation, valid while busy.
- `FpBusy`  out  1  an operation is outstanding.
- `FpWriteW`  out  1  one-cycle FP register-file write strobe.
- `FpRdW`  out  5  destination for `FpWriteW`, held while busy.
- `FpIllegalD`  out  1  rejected-operation pulse (see Configuration).

## Operation
- FSM states: IDLE, START, COUNT.
  - IDLE→START on issue.
  - START→COUNT unconditionally.
  - COUNT→IDLE when the counter reaches 0.
  - COUNT→START when the counter reaches 0 and a new issue occurs in the same cycle.
- Issue condition: `IsFpD & AdvanceD & !FlushE & !FpStallD & legal`.
  - On issue, latch FpOpE ← FpOpD and FpRdW ← InstrD[11:7].
  - Load the counter with LAT−1 for the selected operation (add/sub share LAT_ADD).
- START lasts one cycle and asserts `FpStartE`. COUNT decrements once per cycle.
- `FpWriteW` = (state == COUNT) & (counter == 0). This is the writeback cycle.
- `FpBusy` = state ≠ IDLE.
- `FpStallD` = IsFpD & FpBusy & !wb, OR IsFpD & wb & (rs1 == FpRdW | rs2 == FpRdW).
  - Structural stall while busy.
  - In the writeback cycle, a new op is free to issue unless it reads the register being written. That case costs exactly one extra stall cycle.
- The destination register rd is not hazard-checked.
- `FlushE` only blocks issue. Once started, an operation always completes; only reset cancels it.
- All outputs are registered state or simple decodes of state. No path from `AdvanceD` to `FpStallD`.

## Timing
- Reset (synchronous): state IDLE, counter 0, FpOpE 00, FpRdW 0. All outputs 0.
  - Reset mid-operation drops the operation; no `FpWriteW` follows.
- Issue at edge t → `FpStartE` high in cycle t+1 → `FpWriteW` high in cycle t+1+LAT.
- Back-to-back independent ops: second issue in the first op's writeback cycle gives a throughput of one op per LAT+1 cycles.
- LAT = 1: START is followed by exactly one COUNT cycle, which is the writeback cycle.
- Counter is 5 bits wide; no wrap. A parameter out of range is a compile-time error via an elaborated check.

## Configuration
- `FP_DIV_EN` defined:
  - FDIV.S is legal and uses LAT_DIV.
  - `FpIllegalD` is tied 0.
- `FP_DIV_EN` undefined:
  - FpOpD == 11 is illegal. The LAT_DIV logic is not built.
  - When `IsFpD & AdvanceD & !FlushE & FpOpD == 11`, `FpIllegalD` pulses for that cycle.
  - The op is not issued and never stalls. Other ops are unaffected.

## Test plan
- Reset, then FADD.S rd=5 issued at cycle 10, LAT_ADD=3 → `FpStartE` at 11, `FpWriteW` at 14 with FpRdW=5, `FpBusy` 11..14, IDLE at 15.
- FMUL.S rd=3 issued; next FADD.S reads rs1=7 → `FpStallD` high through COUNT; issues in the writeback cycle; its `FpStartE` immediately follows.
- FMUL.S rd=3 issued; next FSUB.S reads rs2=3 → stalled through the writeback cycle, issues one cycle after it.
- FP op with `FlushE`=1 at the issue edge → no `FpStartE`, `FpBusy` stays 0, no `FpWriteW`.
- FDIV.S rd=9 with LAT_DIV=12 → `FpWriteW` 13 cycles after issue. Repeat the same stimulus without `FP_DIV_EN` → `FpIllegalD` pulses once, `FpBusy` stays 0.
- Assert `reset` during COUNT of FMUL.S → next cycle IDLE, all outputs 0, no `FpWriteW` ever.

Source files
------------

// File: rtl/fp_issue_ctrl_if.sv
// Decode-side and writeback-side signal bundle of the single-outstanding FP issue controller.
// The master modport is the pipeline driving decode information; slave is the controller.
interface fp_issue_ctrl_if;
    logic [31:0] InstrD;
    logic        IsFpD;
    logic [1:0]  FpOpD;
    logic        AdvanceD;
    logic        FlushE;
    logic        FpStallD;
    logic        FpStartE;
    logic [1:0]  FpOpE;
    logic        FpBusy;
    logic        FpWriteW;
    logic [4:0]  FpRdW;
    logic        FpIllegalD;

    modport master (
        output InstrD, IsFpD, FpOpD, AdvanceD, FlushE,
        input  FpStallD, FpStartE, FpOpE, FpBusy, FpWriteW, FpRdW, FpIllegalD
    );

    modport slave (
        input  InstrD, IsFpD, FpOpD, AdvanceD, FlushE,
        output FpStallD, FpStartE, FpOpE, FpBusy, FpWriteW, FpRdW, FpIllegalD
    );
endinterface

// File: rtl/fp_issue_ctrl.sv
// Single-outstanding FP issue/completion controller: times one op with a latency counter, stalls decode on busy/RAW.
// Latency: start pulse one cycle after issue, writeback LAT cycles after start. FP_DIV_EN enables FDIV.S.
module fp_issue_ctrl #(
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 12
) (
    input  logic           clk,
    input  logic           reset,
    fp_issue_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;

    generate
        if (LAT_ADD < 1 || LAT_ADD > 31 || LAT_MUL < 1 || LAT_MUL > 31 ||
            LAT_DIV < 1 || LAT_DIV > 31) begin : g_lat_range_err
            $error("fp_issue_ctrl: latency parameters must lie in 1..31");
        end
    endgenerate

    logic [1:0] state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [4:0] rd_q, rd_d;
    logic [4:0] lat_m1;
    logic [4:0] rs1, rs2;
    logic       busy, wb, legal, issue_req, raw, stall, issue;
    logic       unused_instr;

    assign rs1          = bus.InstrD[19:15];
    assign rs2          = bus.InstrD[24:20];
    assign unused_instr = ^{bus.InstrD[31:25], bus.InstrD[14:12], bus.InstrD[6:0]};

    assign busy      = (state_q != IDLE);
    assign wb        = (state_q == COUNT) && (cnt_q == 5'd0);
    assign issue_req = bus.IsFpD & bus.AdvanceD & ~bus.FlushE;
    assign raw       = (rs1 == rd_q) || (rs2 == rd_q);

`ifdef FP_DIV_EN
    assign legal          = 1'b1;
    assign bus.FpIllegalD = 1'b0;
`else
    assign legal          = (bus.FpOpD != 2'b11);
    assign bus.FpIllegalD = issue_req & (bus.FpOpD == 2'b11);
`endif

    // Stall is a decode of state and decode inputs only, never of AdvanceD.
    assign stall = bus.IsFpD & legal & busy & (~wb | raw);
    assign issue = issue_req & legal & ~stall;

    always_comb begin
        lat_m1 = 5'(LAT_ADD - 1);
        if (bus.FpOpD == 2'b10)
            lat_m1 = 5'(LAT_MUL - 1);
`ifdef FP_DIV_EN
        if (bus.FpOpD == 2'b11)
            lat_m1 = 5'(LAT_DIV - 1);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE:  ;
            START: state_d = COUNT;
            COUNT: begin
                if (cnt_q == 5'd0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 5'd1;
            end
            default: state_d = IDLE;
        endcase
        // Issue is only possible from IDLE or the writeback cycle, so it overrides completion.
        if (issue) begin
            state_d = START;
            cnt_d   = lat_m1;
            op_d    = bus.FpOpD;
            rd_d    = bus.InstrD[11:7];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'b00;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.FpStallD = stall;
    assign bus.FpStartE = (state_q == START);
    assign bus.FpOpE    = op_q;
    assign bus.FpBusy   = busy;
    assign bus.FpWriteW = wb;
    assign bus.FpRdW    = rd_q;
endmodule
